mem_bus_ctrl: RTL

- Non-pipelined AHB-Lite master controller that sequences every bus transfer for the processor core.
- Arbitrates between two requesters: the instruction fetch port and the register-file load/store port (micro-control driven data2Mem/addr2Mem path).
- Generates the HTRANS/HWRITE/HSIZE/HADDR/HWDATA address and data phases, absorbs HREADY wait states and HRESP errors, and returns read data plus a single-cycle done pulse to the winning requester.

---
 rtl/mem_bus_pkg.sv | 40 ++++
 rtl/mem_bus_arb.sv | 48 ++++
 rtl/mem_bus_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and helpers for the AHB-Lite memory bus controller.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_NONSEQ = 2'b10
  } htrans_t;

  typedef logic [2:0] hsize_t;
  localparam hsize_t HSIZE_BYTE = 3'b000;
  localparam hsize_t HSIZE_HALF = 3'b001;
  localparam hsize_t HSIZE_WORD = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_ERR2,
    ST_RESP
  } bus_state_t;

  // Right-aligned store data copied onto every byte lane the slave might pick.
  function automatic logic [31:0] lane_rep(input logic [31:0] d, input logic [1:0] sz);
    case (sz)
      2'd0:    lane_rep = {4{d[7:0]}};
      2'd1:    lane_rep = {2{d[15:0]}};
      default: lane_rep = d;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = a[0];
      2'd2:    misaligned = (a != 2'b00);
      default: misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_bus_arb.sv
// Two-way requester arbiter, grant is one-hot {ls, if}.
// Fixed ls priority by default; MEM_BUS_RR_EN gives round-robin on last served.
module mem_bus_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_if_req,
  input  logic       i_ls_req,
  input  logic       i_upd,
  input  logic       i_served_ls,
  output logic [1:0] o_gnt
);

`ifdef MEM_BUS_RR_EN
  logic r_last_ls;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_ls <= 1'b1;
    end else if (i_upd) begin
      r_last_ls <= i_served_ls;
    end
  end

  always_comb begin
    o_gnt = 2'b00;
    if (i_ls_req && i_if_req) begin
      o_gnt = r_last_ls ? 2'b01 : 2'b10;
    end else if (i_ls_req) begin
      o_gnt = 2'b10;
    end else if (i_if_req) begin
      o_gnt = 2'b01;
    end
  end
`else
  logic w_unused;
  assign w_unused = &{1'b0, clk, rst, i_upd, i_served_ls};

  always_comb begin
    o_gnt = 2'b00;
    if (i_ls_req) begin
      o_gnt = 2'b10;
    end else if (i_if_req) begin
      o_gnt = 2'b01;
    end
  end
`endif

endmodule

// File: rtl/mem_bus_ctrl.sv
// Non-pipelined AHB-Lite master sequencing fetch and load/store transfers.
// MEM_BUS_RR_EN switches the arbiter from fixed ls priority to round-robin.
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int COLS   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [COLS-1:0]   if_rdata,
  output logic              if_err,
  input  logic              ls_req,
  input  logic              ls_write,
  input  logic [1:0]        ls_size,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [COLS-1:0]   ls_wdata,
  output logic              ls_done,
  output logic [COLS-1:0]   ls_rdata,
  output logic              ls_err,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [COLS-1:0]   HWDATA,
  input  logic [COLS-1:0]   HRDATA,
  input  logic              HREADY,
  input  logic              HRESP
);

  bus_state_t        r_state, w_state_nxt;
  htrans_t           r_htrans;
  logic [ADDR_W-1:0] r_haddr;
  logic              r_hwrite;
  hsize_t            r_hsize;
  logic [COLS-1:0]   r_hwdata, r_wdata;
  logic              r_win_ls;
  logic              r_if_done, r_if_err, r_ls_done, r_ls_err;
  logic [COLS-1:0]   r_if_rdata, r_ls_rdata;

  logic [1:0] w_gnt;
  logic       w_issue, w_skip, w_to_data, w_finish, w_fin_err, w_cap, w_fin_ls;

  mem_bus_arb u_arb (
    .clk         (clk),
    .rst         (rst),
    .i_if_req    (if_req),
    .i_ls_req    (ls_req),
    .i_upd       (r_state == ST_RESP),
    .i_served_ls (r_win_ls),
    .o_gnt       (w_gnt)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_skip      = 1'b0;
    w_to_data   = 1'b0;
    w_finish    = 1'b0;
    w_fin_err   = 1'b0;
    w_cap       = 1'b0;
    w_fin_ls    = r_win_ls;
    case (r_state)
      ST_IDLE: begin
        // Illegal ls size/alignment never reaches the bus.
        if (w_gnt[1] && misaligned(ls_size, ls_addr[1:0])) begin
          w_skip      = 1'b1;
          w_finish    = 1'b1;
          w_fin_err   = 1'b1;
          w_fin_ls    = 1'b1;
          w_state_nxt = ST_RESP;
        end else if (|w_gnt) begin
          w_issue     = 1'b1;
          w_state_nxt = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (HREADY) begin
          w_to_data   = 1'b1;
          w_state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (HREADY) begin
          w_cap       = ~HRESP;
          w_finish    = 1'b1;
          w_fin_err   = HRESP;
          w_state_nxt = ST_RESP;
        end else if (HRESP) begin
          w_state_nxt = ST_ERR2;
        end
      end
      ST_ERR2: begin
        if (HREADY) begin
          w_finish    = 1'b1;
          w_fin_err   = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_htrans   <= HTRANS_IDLE;
      r_haddr    <= '0;
      r_hwrite   <= 1'b0;
      r_hsize    <= HSIZE_BYTE;
      r_hwdata   <= '0;
      r_wdata    <= '0;
      r_win_ls   <= 1'b0;
      r_if_done  <= 1'b0;
      r_if_err   <= 1'b0;
      r_if_rdata <= '0;
      r_ls_done  <= 1'b0;
      r_ls_err   <= 1'b0;
      r_ls_rdata <= '0;
    end else begin
      r_if_done <= w_finish & ~w_fin_ls;
      r_ls_done <= w_finish & w_fin_ls;
      if (w_finish) begin
        if (w_fin_ls) r_ls_err <= w_fin_err;
        else          r_if_err <= w_fin_err;
      end
      if (w_cap) begin
        if (r_win_ls) r_ls_rdata <= HRDATA;
        else          r_if_rdata <= HRDATA;
      end
      if (w_skip) r_win_ls <= 1'b1;
      if (w_issue) begin
        r_win_ls <= w_gnt[1];
        r_htrans <= HTRANS_NONSEQ;
        if (w_gnt[1]) begin
          r_haddr  <= ls_addr;
          r_hwrite <= ls_write;
          r_hsize  <= {1'b0, ls_size};
          r_wdata  <= ls_wdata;
        end else begin
          r_haddr  <= if_addr;
          r_hwrite <= 1'b0;
          r_hsize  <= HSIZE_WORD;
          r_wdata  <= '0;
        end
      end
      if (w_to_data) begin
        r_htrans <= HTRANS_IDLE;
        r_hwdata <= lane_rep(r_wdata, r_hsize[1:0]);
      end
    end
  end

  assign HTRANS   = r_htrans;
  assign HADDR    = r_haddr;
  assign HWRITE   = r_hwrite;
  assign HSIZE    = r_hsize;
  assign HWDATA   = r_hwdata;
  assign if_done  = r_if_done;
  assign if_err   = r_if_err;
  assign if_rdata = r_if_rdata;
  assign ls_done  = r_ls_done;
  assign ls_err   = r_ls_err;
  assign ls_rdata = r_ls_rdata;

endmodule
